// File: rtl/finger_game_pkg.sv
// Shared page, key-index and game-result codes for the finger-addition game controller.
package finger_game_pkg;

    typedef enum logic [1:0] {
        PAGE_MAIN   = 2'd0,
        PAGE_HELP   = 2'd1,
        PAGE_CONFIG = 2'd2,
        PAGE_GAME   = 2'd3
    } page_t;

    typedef enum logic [1:0] {
        END_NONE = 2'd0,
        END_P0   = 2'd1,
        END_P1   = 2'd2,
        END_DRAW = 2'd3
    } end_t;

    // Bit positions inside keys = {space, down, right, left, up}; lower index wins.
    localparam int KEY_UP    = 0;
    localparam int KEY_LEFT  = 1;
    localparam int KEY_RIGHT = 2;
    localparam int KEY_DOWN  = 3;
    localparam int KEY_SPACE = 4;
    localparam int NUM_KEYS  = 5;

endpackage

// File: rtl/key_edge_det.sv
// Tick-gated rising-edge detector; the history register only advances on tick.
module key_edge_det #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] prev;

    // Reset loads the live levels so keys held through reset do not fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= din;
        end else if (tick) begin
            prev <= din;
        end
    end

    assign rise = tick ? (din & ~prev) : '0;

endmodule

// File: rtl/finger_game_ctrl.sv
// Page navigation and game-state controller for the finger-addition game.
// Optional per-turn timeout is built when TURN_TIMEOUT_EN is defined.
//
// state       | meaning
// PAGE_MAIN   | title page: up -> CONFIG, down -> HELP
// PAGE_HELP   | rules page: down -> MAIN
// PAGE_CONFIG | hand count edit: left/right adjust, up -> GAME, down -> MAIN
// PAGE_GAME   | play: cursor moves, space selects / adds / exits when ended
module finger_game_ctrl
    import finger_game_pkg::*;
#(
    parameter int MAX_HANDS     = 5,
    parameter int MIN_HANDS     = 2,
    parameter int VAL_W         = 4,
    parameter int MODULUS       = 10,
    parameter int INIT_VAL      = 1,
    parameter int ZERO_RUN      = 2,
    parameter int TIMEOUT_TICKS = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             tick,
    input  logic [4:0]                       keys,
    output logic [1:0]                       page,
    output logic [$clog2(MAX_HANDS+1)-1:0]   hand_num,
    output logic                             cur_row,
    output logic [$clog2(MAX_HANDS)-1:0]     cur_col,
    output logic                             sel_row,
    output logic [$clog2(MAX_HANDS)-1:0]     sel_col,
    output logic                             selecting,
    output logic                             cur_player,
    output logic [2*MAX_HANDS*VAL_W-1:0]     status,
    output logic [VAL_W-1:0]                 predict_value,
    output logic [1:0]                       game_end
);

    localparam int HN_W  = $clog2(MAX_HANDS+1);
    localparam int COL_W = $clog2(MAX_HANDS);
    localparam logic [HN_W-1:0]  HN_MIN = HN_W'(MIN_HANDS);
    localparam logic [HN_W-1:0]  HN_MAX = HN_W'(MAX_HANDS);
    localparam logic [VAL_W:0]   MOD_V  = (VAL_W+1)'(MODULUS);
    localparam logic [VAL_W-1:0] INIT_V = VAL_W'(INIT_VAL);

    if (MODULUS > (1 << VAL_W) || MIN_HANDS > MAX_HANDS || ZERO_RUN < 1 || TIMEOUT_TICKS < 2)
    begin : g_param_check
        $error("finger_game_ctrl: inconsistent parameters");
    end

    page_t               page_q, page_n;
    end_t                end_q, end_n;
    logic [HN_W-1:0]     hn_q, hn_n;
    logic                cur_row_q, cur_row_n, sel_row_q, sel_row_n;
    logic [COL_W-1:0]    cur_col_q, cur_col_n, sel_col_q, sel_col_n;
    logic                selecting_q, selecting_n, player_q, player_n;
    logic [VAL_W-1:0]    hands_q [2][MAX_HANDS];
    logic [VAL_W-1:0]    hands_n [2][MAX_HANDS];
    logic [ZERO_RUN-1:0] hist_q, hist_n;

    logic [4:0]          rise, act;
    logic                move_done, game_start, row0_zero, row1_zero;
    logic                tgt_on_sel;
    logic [COL_W-1:0]    tgt_col, src_col, last_col;
    logic [VAL_W-1:0]    tgt_val, src_val;

`ifdef TURN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_TICKS);
    logic [TO_W-1:0]     to_cnt_q, to_cnt_n;
`endif

    // Operands are always < MODULUS, so one conditional subtract is a full modulo.
    function automatic logic [VAL_W-1:0] add_mod(input logic [VAL_W-1:0] a, input logic [VAL_W-1:0] b);
        logic [VAL_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= MOD_V) s = s - MOD_V;
        return s[VAL_W-1:0];
    endfunction

    key_edge_det #(.WIDTH(NUM_KEYS)) u_edge (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .din  (keys),
        .rise (rise)
    );

    always_comb begin
        act = '0;
        if      (rise[KEY_UP])    act[KEY_UP]    = 1'b1;
        else if (rise[KEY_LEFT])  act[KEY_LEFT]  = 1'b1;
        else if (rise[KEY_RIGHT]) act[KEY_RIGHT] = 1'b1;
        else if (rise[KEY_DOWN])  act[KEY_DOWN]  = 1'b1;
        else if (rise[KEY_SPACE]) act[KEY_SPACE] = 1'b1;
    end

    // The target always sits on the mover's row; whichever of cursor/selection is there.
    assign tgt_on_sel = (sel_row_q == player_q);
    assign tgt_col    = tgt_on_sel ? sel_col_q : cur_col_q;
    assign src_col    = tgt_on_sel ? cur_col_q : sel_col_q;
    assign tgt_val    = hands_q[player_q][tgt_col];
    assign src_val    = hands_q[~player_q][src_col];
    assign last_col   = COL_W'(hn_q - 1'b1);

    always_comb begin
        page_n      = page_q;
        end_n       = end_q;
        hn_n        = hn_q;
        cur_row_n   = cur_row_q;
        cur_col_n   = cur_col_q;
        sel_row_n   = sel_row_q;
        sel_col_n   = sel_col_q;
        selecting_n = selecting_q;
        player_n    = player_q;
        hands_n     = hands_q;
        hist_n      = hist_q;
        move_done   = 1'b0;
        game_start  = 1'b0;
        row0_zero   = 1'b1;
        row1_zero   = 1'b1;
`ifdef TURN_TIMEOUT_EN
        to_cnt_n    = to_cnt_q;
`endif

        case (page_q)
            PAGE_MAIN: begin
                if (act[KEY_UP])        page_n = PAGE_CONFIG;
                else if (act[KEY_DOWN]) page_n = PAGE_HELP;
            end
            PAGE_HELP: begin
                if (act[KEY_DOWN]) page_n = PAGE_MAIN;
            end
            PAGE_CONFIG: begin
                if (act[KEY_LEFT] && hn_q > HN_MIN)  hn_n = hn_q - 1'b1;
                if (act[KEY_RIGHT] && hn_q < HN_MAX) hn_n = hn_q + 1'b1;
                if (act[KEY_DOWN]) page_n = PAGE_MAIN;
                if (act[KEY_UP]) begin
                    page_n      = PAGE_GAME;
                    game_start  = 1'b1;
                    end_n       = END_NONE;
                    cur_row_n   = 1'b0;
                    cur_col_n   = '0;
                    sel_row_n   = 1'b0;
                    sel_col_n   = '0;
                    selecting_n = 1'b0;
                    player_n    = 1'b0;
                    hist_n      = '0;
                    for (int r = 0; r < 2; r++)
                        for (int i = 0; i < MAX_HANDS; i++)
                            hands_n[r][i] = INIT_V;
                end
            end
            PAGE_GAME: begin
                if (act[KEY_UP] || act[KEY_DOWN]) cur_row_n = ~cur_row_q;
                if (act[KEY_LEFT])  cur_col_n = (cur_col_q == '0) ? last_col : cur_col_q - 1'b1;
                if (act[KEY_RIGHT]) cur_col_n = (cur_col_q >= last_col) ? '0 : cur_col_q + 1'b1;
                if (act[KEY_SPACE]) begin
                    if (end_q != END_NONE) begin
                        page_n = PAGE_MAIN;
                    end else if (!selecting_q) begin
                        sel_row_n   = cur_row_q;
                        sel_col_n   = cur_col_q;
                        selecting_n = 1'b1;
                    end else if (sel_row_q == cur_row_q || tgt_val == '0) begin
                        selecting_n = 1'b0;
                    end else begin
                        hands_n[player_q][tgt_col] = add_mod(tgt_val, src_val);
                        hist_n      = ZERO_RUN'({hist_q, (src_val == '0)});
                        player_n    = ~player_q;
                        selecting_n = 1'b0;
                        move_done   = 1'b1;
                    end
                end
            end
            default: page_n = PAGE_MAIN;
        endcase

        if (move_done) begin
            for (int i = 0; i < MAX_HANDS; i++) begin
                if (i < int'(hn_q)) begin
                    if (hands_n[0][i] != '0) row0_zero = 1'b0;
                    if (hands_n[1][i] != '0) row1_zero = 1'b0;
                end
            end
            if (row0_zero)     end_n = END_P0;
            else if (row1_zero) end_n = END_P1;
            else if (&hist_n)   end_n = END_DRAW;
        end

`ifdef TURN_TIMEOUT_EN
        // A key edge on the expiry tick holds the count so the timeout fires next tick.
        if (game_start || move_done) begin
            to_cnt_n = '0;
        end else if (page_q == PAGE_GAME && end_q == END_NONE && tick) begin
            if (to_cnt_q == TO_W'(TIMEOUT_TICKS-1)) begin
                if (rise == '0) begin
                    player_n    = ~player_q;
                    selecting_n = 1'b0;
                    to_cnt_n    = '0;
                end
            end else begin
                to_cnt_n = to_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            page_q      <= PAGE_MAIN;
            end_q       <= END_NONE;
            hn_q        <= HN_MIN;
            cur_row_q   <= 1'b0;
            cur_col_q   <= '0;
            sel_row_q   <= 1'b0;
            sel_col_q   <= '0;
            selecting_q <= 1'b0;
            player_q    <= 1'b0;
            hist_q      <= '0;
            for (int r = 0; r < 2; r++)
                for (int i = 0; i < MAX_HANDS; i++)
                    hands_q[r][i] <= INIT_V;
`ifdef TURN_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            page_q      <= page_n;
            end_q       <= end_n;
            hn_q        <= hn_n;
            cur_row_q   <= cur_row_n;
            cur_col_q   <= cur_col_n;
            sel_row_q   <= sel_row_n;
            sel_col_q   <= sel_col_n;
            selecting_q <= selecting_n;
            player_q    <= player_n;
            hist_q      <= hist_n;
            hands_q     <= hands_n;
`ifdef TURN_TIMEOUT_EN
            to_cnt_q    <= to_cnt_n;
`endif
        end
    end

    always_comb begin
        status = '0;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < MAX_HANDS; i++)
                status[(r*MAX_HANDS+i)*VAL_W +: VAL_W] = hands_q[r][i];
    end

    assign predict_value = (selecting_q && (sel_row_q != cur_row_q))
                         ? add_mod(hands_q[cur_row_q][cur_col_q], hands_q[sel_row_q][sel_col_q])
                         : '0;

    assign page       = page_q;
    assign game_end   = end_q;
    assign hand_num   = hn_q;
    assign cur_row    = cur_row_q;
    assign cur_col    = cur_col_q;
    assign sel_row    = sel_row_q;
    assign sel_col    = sel_col_q;
    assign selecting  = selecting_q;
    assign cur_player = player_q;

endmodule

// File: tb/tb_finger_game_ctrl.sv
// Scoreboard bench for finger_game_ctrl: directed game scripts plus random key traffic.
module tb_finger_game_ctrl;
    import finger_game_pkg::*;

    localparam int MAX_HANDS = 5;
    localparam int MIN_HANDS = 2;
    localparam int VAL_W     = 4;
    localparam int MODULUS   = 10;
    localparam int INIT_VAL  = 1;
    localparam int ZERO_RUN  = 2;
    localparam int HN_W      = $clog2(MAX_HANDS+1);
    localparam int COL_W     = $clog2(MAX_HANDS);
    localparam int SW        = 2*MAX_HANDS*VAL_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tick = 1'b0;
    logic [4:0]       keys = '0;
    logic [1:0]       page;
    logic [HN_W-1:0]  hand_num;
    logic             cur_row, sel_row, selecting, cur_player;
    logic [COL_W-1:0] cur_col, sel_col;
    logic [SW-1:0]    status;
    logic [VAL_W-1:0] predict_value;
    logic [1:0]       game_end;

    finger_game_ctrl #(
        .MAX_HANDS(MAX_HANDS), .MIN_HANDS(MIN_HANDS), .VAL_W(VAL_W), .MODULUS(MODULUS),
        .INIT_VAL(INIT_VAL), .ZERO_RUN(ZERO_RUN), .TIMEOUT_TICKS(1024)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .keys(keys), .page(page), .hand_num(hand_num),
        .cur_row(cur_row), .cur_col(cur_col), .sel_row(sel_row), .sel_col(sel_col),
        .selecting(selecting), .cur_player(cur_player), .status(status),
        .predict_value(predict_value), .game_end(game_end)
    );

    always #5 clk = ~clk;

    typedef struct {
        int page, hn, cr, cc, sr, sc, sel, pl, pv, ge;
        logic [SW-1:0] st;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    logic issued = 1'b0;
    logic chk_en = 1'b0;

    // Reference model state, kept as plain integers.
    int         m_page, m_hn, m_cr, m_cc, m_sr, m_sc, m_sel, m_pl, m_end, m_zrun;
    int         m_hand [2][MAX_HANDS];
    logic [4:0] m_prev;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [SW-1:0] init_st();
        logic [SW-1:0] s;
        for (int i = 0; i < 2*MAX_HANDS; i++) s[i*VAL_W +: VAL_W] = VAL_W'(INIT_VAL);
        return s;
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e.page = m_page; e.hn = m_hn; e.cr = m_cr; e.cc = m_cc; e.sr = m_sr; e.sc = m_sc;
        e.sel = m_sel; e.pl = m_pl; e.ge = m_end;
        e.st = '0;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < MAX_HANDS; i++)
                e.st[(r*MAX_HANDS+i)*VAL_W +: VAL_W] = VAL_W'(m_hand[r][i]);
        e.pv = (m_sel != 0 && m_sr != m_cr) ? (m_hand[m_cr][m_cc] + m_hand[m_sr][m_sc]) % MODULUS : 0;
        return e;
    endfunction

    task automatic model_step(input logic r, input logic t, input logic [4:0] k);
        logic [4:0] rise;
        int act, tc, sc, tv, sv;
        bit z0, z1;
        if (r) begin
            m_page = 0; m_hn = MIN_HANDS; m_cr = 0; m_cc = 0; m_sr = 0; m_sc = 0;
            m_sel = 0; m_pl = 0; m_end = 0; m_zrun = 0; m_prev = k;
            for (int a = 0; a < 2; a++) for (int i = 0; i < MAX_HANDS; i++) m_hand[a][i] = INIT_VAL;
            return;
        end
        if (!t) return;
        rise = k & ~m_prev;
        m_prev = k;
        act = -1;
        for (int b = 4; b >= 0; b--) if (rise[b]) act = b;
        if (act < 0) return;
        case (m_page)
            0: if (act == KEY_UP) m_page = 2; else if (act == KEY_DOWN) m_page = 1;
            1: if (act == KEY_DOWN) m_page = 0;
            2: begin
                if (act == KEY_LEFT && m_hn > MIN_HANDS) m_hn--;
                if (act == KEY_RIGHT && m_hn < MAX_HANDS) m_hn++;
                if (act == KEY_DOWN) m_page = 0;
                if (act == KEY_UP) begin
                    m_page = 3; m_cr = 0; m_cc = 0; m_sr = 0; m_sc = 0; m_sel = 0;
                    m_pl = 0; m_end = 0; m_zrun = 0;
                    for (int a = 0; a < 2; a++) for (int i = 0; i < MAX_HANDS; i++) m_hand[a][i] = INIT_VAL;
                end
            end
            default: begin
                if (act == KEY_UP || act == KEY_DOWN) m_cr = 1 - m_cr;
                if (act == KEY_LEFT)  m_cc = (m_cc + m_hn - 1) % m_hn;
                if (act == KEY_RIGHT) m_cc = (m_cc + 1) % m_hn;
                if (act == KEY_SPACE) begin
                    if (m_end != 0) m_page = 0;
                    else if (m_sel == 0) begin m_sr = m_cr; m_sc = m_cc; m_sel = 1; end
                    else if (m_sr == m_cr) m_sel = 0;
                    else begin
                        if (m_cr == m_pl) begin tc = m_cc; sc = m_sc; end
                        else begin tc = m_sc; sc = m_cc; end
                        tv = m_hand[m_pl][tc];
                        sv = m_hand[1-m_pl][sc];
                        if (tv == 0) m_sel = 0;
                        else begin
                            m_hand[m_pl][tc] = (tv + sv) % MODULUS;
                            m_zrun = (sv == 0) ? m_zrun + 1 : 0;
                            m_pl = 1 - m_pl;
                            m_sel = 0;
                            z0 = 1; z1 = 1;
                            for (int i = 0; i < m_hn; i++) begin
                                if (m_hand[0][i] != 0) z0 = 0;
                                if (m_hand[1][i] != 0) z1 = 0;
                            end
                            if (z0) m_end = 1;
                            else if (z1) m_end = 2;
                            else if (m_zrun >= ZERO_RUN) m_end = 3;
                        end
                    end
                end
            end
        endcase
    endtask

    task automatic cycle(input logic r, input logic t, input logic [4:0] k);
        @(posedge clk);
        #2;
        rst = r; tick = t; keys = k;
        model_step(r, t, k);
        q.push_back(snapshot());
        issued = 1'b1;
    endtask

    task automatic press(input int k);
        cycle(1'b0, 1'b1, 5'(1 << k));
        cycle(1'b0, 1'b1, 5'b0);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 5'b0);
    endtask

    task automatic goto(input int r, input int c);
        if (m_cr != r) press(KEY_UP);
        for (int n = 0; n < MAX_HANDS && m_cc != c; n++) press(KEY_RIGHT);
    endtask

    task automatic do_move(input int tc, input int sc);
        int p;
        p = m_pl;
        goto(1 - p, sc);
        press(KEY_SPACE);
        goto(p, tc);
        press(KEY_SPACE);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_page"}, 64'(page), 0);
        chk({tag, "_hand_num"}, 64'(hand_num), MIN_HANDS);
        chk({tag, "_status"}, 64'(status), 64'(init_st()));
        chk({tag, "_cursor"}, 64'({cur_row, cur_col}), 0);
        chk({tag, "_sel"}, 64'({selecting, sel_row, sel_col}), 0);
        chk({tag, "_player"}, 64'(cur_player), 0);
        chk({tag, "_game_end"}, 64'(game_end), 0);
    endtask

    always @(posedge clk) chk_en <= issued;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (chk_en) begin
            if (q.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL scoreboard_underflow: got 0 entries expected >=1 at %0t", $time);
            end else begin
                e = q.pop_front();
                chk("page", 64'(page), 64'(e.page));
                chk("hand_num", 64'(hand_num), 64'(e.hn));
                chk("cur_row", 64'(cur_row), 64'(e.cr));
                chk("cur_col", 64'(cur_col), 64'(e.cc));
                chk("selecting", 64'(selecting), 64'(e.sel));
                if (e.sel != 0) chk("sel_pos", 64'({sel_row, sel_col}), 64'((e.sr << COL_W) | e.sc));
                chk("cur_player", 64'(cur_player), 64'(e.pl));
                chk("status", 64'(status), 64'(e.st));
                chk("predict_value", 64'(predict_value), 64'(e.pv));
                chk("game_end", 64'(game_end), 64'(e.ge));
            end
        end
    end

    initial begin : stim
        int c, r;
        logic [4:0] k;

        // Reset, then MAIN -> CONFIG, saturation both ways, then GAME.
        cycle(1'b1, 1'b0, 5'b0);
        idle();
        check_reset("reset");
        press(KEY_UP);
        idle();
        chk("dir_page_config", 64'(page), 2);
        repeat (5) press(KEY_RIGHT);
        idle();
        chk("dir_hn_sat_max", 64'(hand_num), 5);
        repeat (5) press(KEY_LEFT);
        idle();
        chk("dir_hn_sat_min", 64'(hand_num), 2);
        press(KEY_UP);
        idle();
        chk("dir_page_game", 64'(page), 3);
        chk("dir_game_status", 64'(status), 64'(init_st()));

        // First move with column wrap: (1,0) onto (0,1).
        press(KEY_UP);
        press(KEY_SPACE);
        press(KEY_LEFT);
        idle();
        chk("dir_col_wrap", 64'(cur_col), 1);
        press(KEY_UP);
        press(KEY_SPACE);
        idle();
        chk("dir_row0_1", 64'(status[VAL_W +: VAL_W]), 2);
        chk("dir_player_after", 64'(cur_player), 1);
        chk("dir_sel_after", 64'(selecting), 0);

        // Reset in the middle of a game with a key held.
        cycle(1'b1, 1'b1, 5'b00001);
        idle();
        check_reset("midgame_reset");
        cycle(1'b0, 1'b1, 5'b0);

        // Script leading to 5 + 7 -> 2, then P0 clears row0.
        press(KEY_UP);
        press(KEY_UP);
        do_move(0, 0); do_move(0, 0); do_move(0, 0);
        do_move(1, 1); do_move(1, 1); do_move(1, 0);
        idle();
        chk("dir_row1_1_is7", 64'(status[(MAX_HANDS+1)*VAL_W +: VAL_W]), 7);
        do_move(0, 1);
        idle();
        chk("dir_mod_wrap", 64'(status[0 +: VAL_W]), 2);
        press(KEY_SPACE);
        idle();
        chk("dir_selecting", 64'(selecting), 1);
        press(KEY_SPACE);
        idle();
        chk("dir_cancel_sel", 64'(selecting), 0);
        chk("dir_cancel_turn", 64'(cur_player), 1);
        do_move(0, 1); do_move(1, 1); do_move(0, 0); do_move(0, 0);
        idle();
        chk("dir_p0_wins", 64'(game_end), 1);
        press(KEY_SPACE);
        idle();
        chk("dir_exit_main", 64'(page), 0);

        // Fresh game ending in a draw after two zero-source moves.
        cycle(1'b1, 1'b0, 5'b0);
        press(KEY_UP);
        press(KEY_UP);
        do_move(0, 0); do_move(0, 0); do_move(0, 0); do_move(0, 0);
        do_move(1, 0); do_move(1, 1); do_move(0, 0); do_move(0, 1);
        do_move(0, 0); do_move(0, 0); do_move(1, 1);
        idle();
        chk("dir_draw", 64'(game_end), 3);

        // Random key traffic.
        for (int n = 0; n < 3000; n++) begin
            c = $urandom_range(0, 199);
            if (c == 0) begin
                cycle(1'b1, 1'($urandom_range(0, 1)), 5'($urandom));
            end else begin
                r = $urandom_range(0, 9);
                if (r < 4)      k = 5'b0;
                else if (r < 9) k = 5'(1 << $urandom_range(0, 4));
                else            k = 5'($urandom);
                cycle(1'b0, 1'($urandom_range(0, 3) != 0), k);
            end
        end

        @(posedge clk);
        #1 issued = 1'b0;
        @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/finger_game_ctrl.md
Name: finger_game_ctrl

Overview:
- Parametrised page-navigation and game-state controller for the PS2-driven finger-addition game.
- Consumes debounced key levels (up/left/right/down/space) from the PS2 decoder.
- Owns the page FSM, the configuration value, cursor/selection and per-hand values, and exposes them to the page renderers and VGA mux.
- Generalises hand count, modulus, initial value and draw rule; adds a synchronous reset and exit-from-game.

Parameters:
MAX_HANDS, 5, hands per player (upper bound of configuration)
MIN_HANDS, 2, lower bound of configuration; also reset value of hand_num
VAL_W, 4, bits per hand value
MODULUS, 10, addition modulus (must be <= 2**VAL_W)
INIT_VAL, 1, value loaded into every hand at game start
ZERO_RUN, 2, consecutive zero-valued additions that end the game as a draw
TIMEOUT_TICKS, 1024, ticks per turn (used only with TURN_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  reset
tick  in  1  sampling enable (clkdiv tap); all state changes only on tick=1
keys  in  5  key levels {space,down,right,left,up}
page  out  2  0 MAIN, 1 HELP, 2 CONFIG, 3 GAME
hand_num  out  $clog2(MAX_HANDS+1)  configured hands per player
cur_row  out  1  cursor player row
cur_col  out  $clog2(MAX_HANDS)  cursor hand index
sel_row  out  1  latched selection row
sel_col  out  $clog2(MAX_HANDS)  latched selection index
selecting  out  1  a source hand is latched
cur_player  out  1  player to move
status  out  2*MAX_HANDS*VAL_W  hand values; row r, hand i at offset (r*MAX_HANDS+i)*VAL_W
predict_value  out  VAL_W  preview of the sum
game_end  out  2  0 running, 1 player0 wins, 2 player1 wins, 3 draw

Behaviour:
- Reset and clock: one clock; reset is synchronous and active-high.
- Reset values: page=0, hand_num=MIN_HANDS, all hands=INIT_VAL, cursor/selection=0, selecting=0, cur_player=0, game_end=0, zero-run history=0, prev_keys=keys.
- Reset mid-game discards all game state.
- Edge detection: a rising edge on a key is prev=0 & cur=1, evaluated on tick.
- prev_keys updates on every tick.
- At most one action per tick; priority is up>left>right>down>space. Losing edges are dropped.
- MAIN: up->CONFIG; down->HELP.
- HELP: down->MAIN.
- CONFIG: left decrements hand_num, saturating at MIN_HANDS; right increments, saturating at MAX_HANDS; down->MAIN.
- CONFIG up->GAME, and on the same edge loads the game init state: all 2*MAX_HANDS hands=INIT_VAL, cursor=(0,0), selecting=0, cur_player=0, game_end=0, history=0.
- GAME up/down: toggle cur_row.
- GAME left/right: cur_col -/+1, wrapping within 0..hand_num-1.
- GAME space, game_end!=0: return to MAIN; game state is held.
- GAME space, selecting=0: latch sel=cursor, set selecting=1.
- GAME space, selecting=1, sel_row==cur_row: cancel. Clear selecting; turn unchanged.
- GAME space, selecting=1, rows differ: target is the hand on row cur_player, source is the other hand.
- If target==0: cancel; turn unchanged.
- Otherwise: target <= (target+source) mod MODULUS, computed at VAL_W+1 bits.
- Shift (source==0) into the ZERO_RUN-deep history.
- Toggle cur_player and clear selecting.
- game_end is evaluated in the same edge on post-update values, priority 1>2>3:
  - 1: all of row0 hands 0..hand_num-1 are zero.
  - 2: same for row1.
  - 3: history all ones.
- Hands with index >= hand_num are excluded from the end check and never modified.
- predict_value (combinational) = (status[cursor]+status[sel]) mod MODULUS when selecting=1 and rows differ; else 0.

Optional Feature:
- Macro: TURN_TIMEOUT_EN.
- With the macro:
  - A turn counter increments on tick while page=GAME and game_end=0.
  - It clears on every completed move and on game start.
  - On reaching TIMEOUT_TICKS-1, cur_player toggles, selecting clears and the counter clears. Hands and history are unchanged.
  - A key action in the same tick takes precedence; the timeout is deferred one tick.
- Without the macro: no counter logic; TIMEOUT_TICKS is ignored.

Decomposition:
- Package finger_game_pkg holds:
  - page codes PAGE_MAIN/HELP/CONFIG/GAME;
  - key bit indices KEY_UP..KEY_SPACE;
  - game_end codes END_NONE/P0/P1/DRAW.
- One sub-module, key_edge_det: WIDTH-parametrised, tick-gated rising-edge detector with synchronous reset.

Test Plan:
- Reset, then up, then up (tick high) -> page 0->2->3; hand_num=2; all hands=1; cur_player=0.
- CONFIG: right x5, then left x5 -> hand_num saturates at 5, then returns to 2 saturated; no wrap.
- GAME (hands=2): space at (1,0), then left wraps cur_col to 1, then up moves to row0, space at (0,1) -> status row0[1]=2, cur_player=1, selecting=0.
- Hand values 7 and 5 added -> result 2 (mod 10). Same-row second space -> selecting=0 and cur_player unchanged.
- Row0 reduced to all zero on a move -> game_end=1 in the same edge; next space -> page=0.
- Two consecutive moves with zero source -> game_end=3. Reset asserted mid-game -> all outputs return to reset values on the next edge.
